// File: rtl/subword_serial_unit.sv
// Byte-serial AES SubWord: one shared external S-box, four SUB cycles per word, valid/ready on both sides.
// Optional feature macro SUBWORD_ROTWORD_EN rotates the word on capture (SubWord(RotWord(w))).
module subword_serial_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_word_i,
   output logic [1:0]  sel_o,
   output logic [7:0]  sbox_in_o,
   input  logic [7:0]  sbox_out_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_word_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] word_q, word_d;
   logic [31:0] out_word_q, out_word_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        in_ready_s;
   logic        in_xfer_s;
   logic        out_xfer_s;

   function automatic logic [31:0] capture_word(input logic [31:0] w);
`ifdef SUBWORD_ROTWORD_EN
      return {w[23:0], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Byte 0 of the sequence is the most significant lane.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
      logic [7:0] b;
      case (s)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         2'd3:    b = w[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [31:0] lane_write(input logic [31:0] w, input logic [1:0] s,
                                              input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (s)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         2'd3:    r[7:0]   = b;
         default: r = w;
      endcase
      return r;
   endfunction

   // Input acceptance depends only on state and the downstream ready.
   always_comb begin
      in_ready_s = 1'b0;
      case (state_q)
         ST_IDLE: in_ready_s = 1'b1;
         ST_SUB:  in_ready_s = 1'b0;
         ST_DONE: in_ready_s = out_ready_i;
         default: in_ready_s = 1'b0;
      endcase
   end

   assign in_xfer_s  = in_valid_i & in_ready_s;
   assign out_xfer_s = out_valid_q & out_ready_i;

   // Next-state, byte sequencing and result reassembly.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      word_d     = word_q;
      out_word_d = out_word_q;
      case (state_q)
         ST_IDLE: begin
            if (in_xfer_s) begin
               state_d = ST_SUB;
               word_d  = capture_word(in_word_i);
               sel_d   = 2'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SUB: begin
            out_word_d = lane_write(out_word_q, sel_q, sbox_out_i);
            sel_d      = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SUB;
            end
         end
         ST_DONE: begin
            if (out_xfer_s && in_xfer_s) begin
               state_d = ST_SUB;
               word_d  = capture_word(in_word_i);
               sel_d   = 2'd0;
            end else if (out_xfer_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = 2'd0;
         end
      endcase
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d == ST_SUB);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         sel_q       <= 2'd0;
         word_q      <= 32'h0000_0000;
         out_word_q  <= 32'h0000_0000;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         word_q      <= word_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // S-box input is a mux of registered state; forced to zero outside SUB.
   always_comb begin
      if (state_q == ST_SUB) begin
         sbox_in_o = byte_of(word_q, sel_q);
      end else begin
         sbox_in_o = 8'h00;
      end
   end

   assign in_ready_o  = in_ready_s;
   assign sel_o       = sel_q;
   assign out_valid_o = out_valid_q;
   assign out_word_o  = out_word_q;
   assign busy_o      = busy_q;

endmodule

// File: doc/subword_serial_unit.md
# subword_serial_unit

Byte-serial SubWord engine that applies the AES S-box to a 32-bit word using one shared 8-bit S-box instance over four consecutive cycles. It sits directly downstream of the 2-bit byte-select sequencer: it registers a word and steers one byte per cycle into the S-box under a 0→1→2→3 select sequence. It reassembles the substituted bytes and presents the 32-bit result through a valid/ready handshake. It serves key expansion (SubWord) and column-serial SubBytes.

## Interface
- No parameters; the byte count is fixed at 4 and the byte width at 8.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_word is valid this cycle.
- in_ready  output  1  block accepts a word this cycle; transfer when in_valid & in_ready at a rising edge.
- in_word  input  32  word to substitute.
- sel  output  2  current byte index; drives byte steering and is exported for debug.
- sbox_in  output  8  byte presented to the external combinational S-box.
- sbox_out  input  8  S-box result for sbox_in, same cycle.
- out_valid  output  1  out_word holds a complete result.
- out_ready  input  1  consumer takes result; transfer when out_valid & out_ready at a rising edge.
- out_word  output  32  substituted word.
- busy  output  1  high in SUB state.

## Operation
- States: IDLE, SUB, DONE. Reset enters IDLE with sel=0, out_valid=0, out_word=0, busy=0, and the internal word register cleared. in_ready=1 once reset is released.
- IDLE: in_ready=1. On an input transfer, capture in_word, go to SUB, and set sel=0.
- SUB: sbox_in is the captured byte selected by sel.
  - sel=0 selects bits [31:24]; sel=1 selects [23:16]; sel=2 selects [15:8]; sel=3 selects [7:0].
  - Each edge writes sbox_out into the same byte lane of out_word and increments sel by 1, wrapping mod 4.
  - On the edge with sel=3, go to DONE, sel wraps to 0, and set out_valid=1.
  - in_ready=0 throughout SUB.
- DONE: out_word and out_valid are held stable until an output transfer.
  - Output transfer with no simultaneous input transfer: go to IDLE.
  - in_ready = out_ready in DONE. A simultaneous output transfer and input transfer captures the new word, goes straight to SUB, and clears out_valid.
- sbox_in = 0 outside SUB. out_word lanes not yet rewritten in SUB keep their prior value. Consumers must only sample out_word when out_valid=1.
- Reset asserted mid-operation returns the block to IDLE immediately. The partial result is discarded; no output transfer occurs for that word.
- in_valid in SUB is ignored and the word is not captured. The producer must hold it until in_ready.

## Timing
- Throughput: one word per 5 cycles in back-to-back operation.
  - One capture edge, four SUB cycles; the DONE cycle overlaps the next capture.
- Latency: input transfer at edge E gives out_valid=1 after edge E+4, i.e. visible in the cycle after E+4.
- The S-box path is combinational within one cycle: sbox_in is from a register, and sbox_out is registered into out_word.
- in_ready is combinational from state and out_ready only. There is no combinational path from in_valid to any output.
- out_valid, out_word, sel and busy are registered outputs.

## Configuration
- SUBWORD_ROTWORD_EN defined: the captured word is RotWord(in_word) = {in_word[23:0], in_word[31:24]}, so out_word = SubWord(RotWord(in_word)). This is used for key-expansion word i mod Nk = 0.
- Not defined: out_word = SubWord(in_word). The capture path has no rotation logic.
- Ports and timing are identical in both builds.

## Test plan
- Reset, then in_word=0x00010253 with out_ready=1 -> sbox_in sequence 0x00,0x01,0x02,0x53; out_valid after edge E+4; out_word=0x637C77ED; one-cycle out_valid pulse.
- Build without macro, in_word=0x09CF4F3C -> out_word=0x018A84EB. Build with SUBWORD_ROTWORD_EN, same input -> out_word=0x8A84EB01.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_word held stable; in_ready=0; a new in_valid is not captured until the output transfers.
- Back-to-back: in_valid held high with words 0xFFFFFFFF then 0x00000000 and out_ready=1 -> results 0x16161616 then 0x63636363; out_valid asserted every 5 cycles.
- Reset mid-SUB (rst low while sel=2) -> all outputs at reset values immediately (sel=0, out_valid=0, out_word=0); after release the next word produces the correct result.
- in_valid pulsed during SUB with a different word -> ignored; result equals the SubWord of the originally captured word.
